// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle MIPS multiply/divide unit owning the HI/LO registers
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  MD_OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic commit_q, commit_d, done_q, done_d;
  logic is_md, is_div, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_b, q_u, r_u, q_s, r_s;
  logic [63:0] prod_s, prod_u;
  always_comb begin
    is_md = (MD_OP != 3'd0) && (MD_OP <= 3'd4);
    is_div = (MD_OP == 3'd3) || (MD_OP == 3'd4);
    a_neg = (MD_OP == 3'd3) && A[31];
    b_neg = (MD_OP == 3'd3) && B[31];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
    div_b = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_u = a_mag / div_b;
    r_u = a_mag % div_b;
    q_s = (a_neg ^ b_neg) ? -q_u : q_u;
    r_s = a_neg ? -r_u : r_u;
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    commit_d = commit_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start && is_md) begin
        state_d = RUN;
        cnt_d = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        {pend_hi_d, pend_lo_d} = (MD_OP == 3'd1) ? prod_s : (MD_OP == 3'd2) ? prod_u : {r_s, q_s};
        commit_d = !(is_div && (B == 32'd0));
      end else if (start) begin
        hi_d = (MD_OP == 3'd5) ? A : hi_q;
        lo_d = (MD_OP == 3'd6) ? A : lo_q;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        done_d = 1'b1;
        hi_d = commit_q ? pend_hi_q : hi_q;
        lo_d = commit_q ? pend_lo_q : lo_q;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      commit_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      commit_q <= commit_d;
      done_q <= done_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign HI = hi_q;
  assign LO = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: randomized and directed checks of mdu_unit against a behavioural model
module tb_mdu_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 0, reset_n = 0, start = 0;
  logic [2:0] MD_OP = 0;
  logic [31:0] A = 0, B = 0;
  logic busy, done;
  logic [31:0] HI, LO;
  int checks = 0, fails = 0;
  bit chk_en = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  int left = 0;
  bit m_done = 0, p_ok = 0;
  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .MD_OP(MD_OP), .A(A), .B(B),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    p = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p_ok = 1;
    if (op == 1) begin
      p = 64'(sa * sb);
      left = MC;
    end else if (op == 2) begin
      p = {32'd0, a} * {32'd0, b};
      left = MC;
    end else if (op == 3 || op == 4) begin
      left = DC;
      if (b == 0) p_ok = 0;
      else begin
        if (op == 4) begin
          sa = longint'({32'd0, a});
          sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        p = {32'(r), 32'(q)};
      end
    end else if (op == 5) m_hi = a;
    else if (op == 6) m_lo = a;
    if (op >= 1 && op <= 4 && p_ok) {p_hi, p_lo} = p;
  endtask
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_hi = 0;
      m_lo = 0;
      left = 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          m_done = 1;
          if (p_ok) begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
        end
      end else if (start) model_cmd(MD_OP, A, B);
    end
  end
  initial forever begin
    @(negedge clk);
    if (reset_n && chk_en) begin
      chk("cyc_busy", 32'(busy), 32'(left > 0));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_hi", HI, m_hi);
      chk("cyc_lo", LO, m_lo);
    end
  end
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1; MD_OP = op; A = a; B = b;
    @(negedge clk);
    start = 0; MD_OP = 0; A = $urandom; B = $urandom;
  endtask
  task automatic wait_idle(input int exp_n, input string nm);
    int n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 32'(n), 32'(exp_n));
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    repeat (3) @(negedge clk);
    reset_n = 1;
    chk_en = 1;
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(MC, "mult_busy");
    chk("mult_done", 32'(done), 1);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    chk("model_mult_lo", m_lo, 32'hFFFF_FFFA);
    @(negedge clk);
    chk("mult_done_pulse", 32'(done), 0);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(MC, "multu_busy");
    chk("multu_hi", HI, 32'hFFFF_FFFE);
    chk("multu_lo", LO, 32'h0000_0001);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(DC, "div_busy");
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    chk("model_div_hi", m_hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(DC, "divovf_busy");
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'h0);
    issue(3'd5, 32'h1234, 32'd0);
    wait_idle(0, "mthi_busy");
    chk("mthi_done", 32'(done), 0);
    chk("mthi_hi", HI, 32'h1234);
    issue(3'd6, 32'h5678, 32'd0);
    chk("mtlo_lo", LO, 32'h5678);
    issue(3'd4, 32'd100, 32'd0);
    wait_idle(DC, "divz_busy");
    chk("divz_done", 32'(done), 1);
    chk("divz_hi", HI, 32'h1234);
    chk("divz_lo", LO, 32'h5678);
    issue(3'd1, 32'd7, 32'd9);
    start = 1; MD_OP = 3'd6; A = 32'hAAAA; B = 32'h5555;
    @(negedge clk);
    start = 0; MD_OP = 0; A = $urandom; B = $urandom;
    wait_idle(MC - 1, "ignore_busy");
    chk("ignore_hi", HI, 32'd0);
    chk("ignore_lo", LO, 32'd63);
    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_hi", HI, 0);
    chk("arst_lo", LO, 0);
    @(negedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    chk("mflo_after_rst", LO, 0);
    chk("busy_after_rst", 32'(busy), 0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      MD_OP = 3'($urandom_range(0, 7));
      A = pick();
      B = pick();
    end
    @(negedge clk);
    start = 0;
    repeat (DC + 2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit that sits beside the ALU in the EX stage of the MIPS pipeline.
- It takes the same 32-bit operand pair (A = rs, B = rt) that feeds the ALU.
- It executes mult/multu/div/divu over several cycles and owns the architectural HI/LO registers.
- It serves mthi/mtlo writes and mfhi/mflo reads, and raises busy so the hazard unit can stall the next MD instruction.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, number of busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle command strobe; MD_OP, A and B are sampled on this edge.
- MD_OP  in  3  command: 0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as nop).
- A  in  32  operand rs.
- B  in  32  operand rt.
- busy  out  1  high while a mult/div is in flight.
- done  out  1  one-cycle pulse on the cycle HI/LO first show a new mult/div result.
- HI  out  32  architectural HI register (mfhi source).
- LO  out  32  architectural LO register (mflo source).

Behaviour:
- Reset:
  - reset_n low clears HI, LO, the counter and done; busy goes 0 immediately, with no clock edge needed.
  - State: IDLE.
  - Reset mid-operation aborts the operation; the result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counting down.
  - IDLE -> RUN on an edge with start=1 and MD_OP in 1..4. The counter loads MULT_CYCLES or DIV_CYCLES.
  - RUN decrements the counter each edge. On the edge where the counter equals 1:
    - commit the pending result to HI/LO;
    - set done=1 for the next cycle;
    - return to IDLE.
- Timing: start at edge t gives busy=1 during exactly N cycles (t+1 .. t+N). HI/LO are new and busy=0 from edge t+N onward.
- Operands are latched at start. Later changes to A/B do not affect the result.
- The result may be computed at the start edge into a shadow register; only the commit is delayed.
- mthi/mtlo while IDLE: HI or LO = A at the next edge, busy stays 0, done stays 0.
- start while busy=1 (any MD_OP) is ignored. The hazard unit guarantees a stall; this behaviour is also the defined fallback.
- mult: signed 32x32 -> 64-bit product; {HI, LO} = product.
- multu: unsigned 32x32 -> 64-bit product; {HI, LO} = product.
- div: signed. LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- div overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned. LO = quotient, HI = remainder.
- Divide by zero (div or divu):
  - busy still runs the full DIV_CYCLES;
  - HI/LO are left unchanged;
  - done still pulses.
- nop/reserved with start=1: no effect.
- HI/LO are plain register outputs: the mfhi/mflo path is read directly, with no forwarding from a pending result.

Test Plan:
- Reset: reset_n low mid-RUN of a div -> busy, done, HI and LO are 0 asynchronously. After release, an mflo read returns 0.
- mult, A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulse 1 cycle.
- multu, A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div, A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div, 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu 100/0 after mthi 0x1234 and mtlo 0x5678 -> busy 10 cycles, HI=0x1234, LO=0x5678 unchanged.
- During a running mult: apply mtlo A=0xAAAA with start=1 and change A/B -> both ignored; the final mult result matches the operands latched at start.
